hamming_mem_arbiter: RTL and testbench
======================================

# hamming_mem_arbiter

Arbitrated controller for a (16,11) SECDED Hamming-protected word store. It shares one encoder, one decoder and one DEPTH×16 memory between two requesters (A and B) using round-robin arbitration. On reads it corrects single-bit errors and optionally writes the corrected word back (scrub), flags double-bit errors, and keeps error statistics. It sits between client logic and the Hamming storage.

## Interface
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W words
- SCRUB_EN, 1, 1 = write corrected codeword back on a single-bit error
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- a_valid, b_valid  in  1  request valid per client
- a_ready, b_ready  out  1  request accepted this cycle when valid&&ready
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  ADDR_W  word address
- a_wdata, b_wdata  in  11  write data
- inj_mask  in  16  test hook: XORed into the encoded codeword on writes only
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  0 = client A, 1 = client B
- rsp_rdata  out  11  read data (corrected when possible); 0 for writes
- rsp_err  out  2  00 ok, 01 corrected single, 10 uncorrectable double
- corr_count, uncorr_count  out  16  saturating error counters

## Operation
- Codeword bit i = Hamming position i. Bit0 = p0, bit1 = p1, bit2 = p2, bit4 = p4, bit8 = p8. Bit3 = d0; bits 7:5 = d3:d1; bits 15:9 = d10:d4.
- pk (k = 1,2,4,8) = XOR of data bits whose position has bit k set.
- p0 makes the XOR of all 16 bits equal to 0 (even overall parity).
- Decode: s = XOR of the positions of all set bits in 1..15; P = XOR of all 16 bits.
  - s=0, P=0: err 00.
  - P=1: err 01. Flip bit s, or bit0 if s=0; returned data comes from the corrected word.
  - s≠0, P=0: err 10. Data is returned raw from the stored bits, no correction.
- FSM states: IDLE, ACCESS, CHECK, WRBACK, RESP.
  - IDLE: ready asserted only to the arbitration winner; on accept, latch id/we/addr/wdata, go to ACCESS.
  - ACCESS, write: mem[addr] <= encode(wdata) ^ inj_mask at the end of the cycle, then RESP.
  - ACCESS, read: codeword register <= mem[addr], then CHECK.
  - CHECK: decode, latch rdata/err, update counters. If err=01 and SCRUB_EN=1, go to WRBACK (mem[addr] <= corrected codeword); otherwise go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle with id/rdata/err, then IDLE. There is no response backpressure.
- Arbitration: only one client is granted per transaction.
  - Both valid: grant the client not granted last.
  - The last-grant pointer resets to B, so A wins the first tie.
  - Single valid: that client wins regardless of the pointer.
- Both ready outputs are low in every state except IDLE.
- The other client's held request waits and is served after RESP.
- Counters: corr_count increments on err=01 and uncorr_count on err=10, both in CHECK. Each holds at 16'hFFFF.
- Memory contents are not reset. Reading a never-written address gives undefined data.

## Timing
- Reset (rst_n=0 at a posedge):
  - state=IDLE, last-grant=B.
  - a_ready, b_ready, rsp_valid = 0; rsp_id, rsp_rdata, rsp_err = 0; counters = 0.
- While rst_n=0, ready stays low.
- Reset asserted mid-transaction aborts it: no rsp_valid, no further memory write. A write already committed at the ACCESS edge persists.
- Accept cycle = cycle 0.
  - Write: ACCESS in cycle 1, rsp_valid in cycle 2.
  - Read: rsp_valid in cycle 3, or cycle 4 with scrub.
- The next accept can occur in the cycle after RESP at the earliest. Peak throughput is 1 write per 3 cycles.
- Ready is combinational from state, the valids and the pointer.
- Inputs are sampled only at the accept edge. Changes to request inputs while not accepted are ignored.
- Write then read of the same address, back to back: the read returns the new data.

## Test plan
- After reset, A writes addr 3, data 11'h001, inj_mask 0 -> stored codeword 16'h000F; rsp_valid in cycle 2 with id 0, err 00. Read addr 3 -> rdata 11'h001, err 00, rsp in cycle 3.
- Write addr 5, data 11'h7FF -> codeword 16'hFFFF. Write addr 6, data 11'h7FF, inj_mask 16'h0020 -> read of addr 6 gives rdata 11'h7FF, err 01, corr_count 1, WRBACK occurs. Re-reading addr 6 -> err 00, corr_count unchanged.
- inj_mask 16'h0001 on a write (p0 flip) -> read gives err 01 with correct data.
- inj_mask 16'h0022 (bits 1 and 5 flipped) -> read gives err 10, uncorr_count 1, no writeback.
- a_valid and b_valid both held high for 4 transactions -> grant order A, B, A, B, with rsp_id matching.
- b_valid alone -> B served immediately.
- Reset pulsed during CHECK of a read -> no rsp_valid, counters 0, next request served normally.
- SCRUB_EN=0 build -> a single-bit error read returns err 01 on every repeat read, and corr_count increments each time.

Source files
------------

// File: rtl/hamming_mem_arbiter.sv
// hamming_mem_arbiter: two-client round-robin front end to a DEPTH x 16 SECDED (16,11) word store.
// One shared encoder/decoder; single-bit errors are corrected (and optionally scrubbed back),
// double-bit errors are flagged, and both kinds are counted with saturating counters.
module hamming_mem_arbiter #(
    parameter int unsigned ADDR_W   = 4,
    parameter bit          SCRUB_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [10:0]       a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [10:0]       b_wdata,
    input  logic [15:0]       inj_mask,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [10:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [15:0]       corr_count,
    output logic [15:0]       uncorr_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Parity-group masks: bit i of the mask is set when Hamming position i has bit k set.
    localparam logic [15:0] GroupP1 = 16'hAAAA;
    localparam logic [15:0] GroupP2 = 16'hCCCC;
    localparam logic [15:0] GroupP4 = 16'hF0F0;
    localparam logic [15:0] GroupP8 = 16'hFF00;

    localparam logic [1:0] ErrNone   = 2'b00;
    localparam logic [1:0] ErrSingle = 2'b01;
    localparam logic [1:0] ErrDouble = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StCheck,
        StWrback,
        StResp
    } stateT;

    // Place data bits at the non-power-of-two positions, then fill p1..p8 and overall parity p0.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c    = {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
        // Each group mask covers its own (still zero) parity position, so order does not matter.
        c[1] = ^(c & GroupP1);
        c[2] = ^(c & GroupP2);
        c[4] = ^(c & GroupP4);
        c[8] = ^(c & GroupP8);
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extractData(input logic [15:0] c);
        return {c[15:9], c[7:5], c[3]};
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    stateT              stateQ;
    logic               lastGrantB;
    logic               idQ;
    logic               weQ;
    logic [ADDR_W-1:0]  addrQ;
    logic [10:0]        wdataQ;
    logic [15:0]        maskQ;
    logic [15:0]        codeQ;

    logic [15:0]        mem [DEPTH];

    logic               grantA;
    logic               grantB;
    logic [3:0]         syndrome;
    logic               overallPar;
    logic [15:0]        fixedCode;
    logic [1:0]         decErr;
    logic [10:0]        decData;
    logic               memWe;
    logic [15:0]        memWdata;

    // Round-robin pick: on a tie the client not granted last wins, otherwise the lone requester.
    always_comb begin
        grantA = a_valid && (!b_valid || lastGrantB);
        grantB = b_valid && !grantA;
    end

    // Ready is offered only in IDLE, only to the winner, and never while reset is held.
    always_comb begin
        a_ready = rst_n && (stateQ == StIdle) && grantA;
        b_ready = rst_n && (stateQ == StIdle) && grantB;
    end

    // SECDED decode of the fetched codeword.
    always_comb begin
        syndrome   = {^(codeQ & GroupP8), ^(codeQ & GroupP4),
                      ^(codeQ & GroupP2), ^(codeQ & GroupP1)};
        overallPar = ^codeQ;
        // A zero syndrome with odd parity means p0 itself flipped, which is bit 0.
        fixedCode  = codeQ ^ (16'd1 << syndrome);
        decErr     = ErrNone;
        decData    = extractData(codeQ);
        if (overallPar) begin
            decErr  = ErrSingle;
            decData = extractData(fixedCode);
        end else if (syndrome != 4'd0) begin
            decErr  = ErrDouble;
        end
    end

    // Memory write port: client writes in ACCESS, corrected codeword in WRBACK; reset blocks both.
    always_comb begin
        memWe    = rst_n && (((stateQ == StAccess) && weQ) || (stateQ == StWrback));
        memWdata = (stateQ == StWrback) ? codeQ : (encode(wdataQ) ^ maskQ);
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[addrQ] <= memWdata;
        end
    end

    // Transaction FSM with registered response and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ       <= StIdle;
            lastGrantB   <= 1'b1;
            idQ          <= 1'b0;
            weQ          <= 1'b0;
            addrQ        <= '0;
            wdataQ       <= '0;
            maskQ        <= '0;
            codeQ        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= ErrNone;
            corr_count   <= '0;
            uncorr_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (grantA || grantB) begin
                        idQ        <= grantB;
                        lastGrantB <= grantB;
                        weQ        <= grantB ? b_we    : a_we;
                        addrQ      <= grantB ? b_addr  : a_addr;
                        wdataQ     <= grantB ? b_wdata : a_wdata;
                        maskQ      <= inj_mask;
                        stateQ     <= StAccess;
                    end
                end
                StAccess: begin
                    if (weQ) begin
                        rsp_id    <= idQ;
                        rsp_rdata <= '0;
                        rsp_err   <= ErrNone;
                        rsp_valid <= 1'b1;
                        stateQ    <= StResp;
                    end else begin
                        codeQ  <= mem[addrQ];
                        stateQ <= StCheck;
                    end
                end
                StCheck: begin
                    rsp_id    <= idQ;
                    rsp_rdata <= decData;
                    rsp_err   <= decErr;
                    // Keep the corrected word around for a possible scrub write.
                    codeQ     <= fixedCode;
                    if (decErr == ErrSingle) begin
                        corr_count <= satInc(corr_count);
                    end
                    if (decErr == ErrDouble) begin
                        uncorr_count <= satInc(uncorr_count);
                    end
                    if ((decErr == ErrSingle) && SCRUB_EN) begin
                        stateQ <= StWrback;
                    end else begin
                        rsp_valid <= 1'b1;
                        stateQ    <= StResp;
                    end
                end
                StWrback: begin
                    rsp_valid <= 1'b1;
                    stateQ    <= StResp;
                end
                StResp: begin
                    stateQ <= StIdle;
                end
                default: begin
                    stateQ <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_mem_arbiter.sv
// tb_hamming_mem_arbiter: directed table, arbitration/reset sequences and a randomized run
// checked against a positional Hamming reference model.
module tb_hamming_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_valid, b_valid, a_we, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [10:0] a_wdata, b_wdata;
    logic [15:0] inj_mask;
    wire         a_ready, b_ready, rsp_valid, rsp_id;
    wire  [10:0] rsp_rdata;
    wire  [1:0]  rsp_err;
    wire  [15:0] corr_count, uncorr_count;

    // Second instance built without scrubbing, driven through its A port only.
    logic        nValid, nWe;
    logic [3:0]  nAddr;
    logic [10:0] nWdata;
    logic [15:0] nMask;
    wire         nReady, nBReady, nRspValid, nRspId;
    wire  [10:0] nRspRdata;
    wire  [1:0]  nRspErr;
    wire  [15:0] nCorr, nUncorr;

    hamming_mem_arbiter #(.ADDR_W(4), .SCRUB_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .inj_mask(inj_mask), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    hamming_mem_arbiter #(.ADDR_W(4), .SCRUB_EN(1'b0)) dutNoScrub (
        .clk(clk), .rst_n(rst_n),
        .a_valid(nValid), .a_ready(nReady), .a_we(nWe), .a_addr(nAddr), .a_wdata(nWdata),
        .b_valid(1'b0), .b_ready(nBReady), .b_we(1'b0), .b_addr(4'd0), .b_wdata(11'd0),
        .inj_mask(nMask), .rsp_valid(nRspValid), .rsp_id(nRspId), .rsp_rdata(nRspRdata),
        .rsp_err(nRspErr), .corr_count(nCorr), .uncorr_count(nUncorr)
    );

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (positional Hamming arithmetic) ----------------
    function automatic bit isPow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [15:0] mEnc(input logic [10:0] d);
        logic [15:0] c;
        int k, s;
        c = '0; k = 0; s = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if (!isPow2(pos)) begin
                c[pos] = d[k];
                if (d[k]) s = s ^ pos;
                k++;
            end
        end
        c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
        c[0] = ($countones(c) % 2) == 1;
        return c;
    endfunction

    function automatic logic [10:0] mExt(input logic [15:0] c);
        logic [10:0] d;
        int k;
        d = '0; k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if (!isPow2(pos)) begin
                d[k] = c[pos];
                k++;
            end
        end
        return d;
    endfunction

    // Returns err; fills data and corrected word.
    function automatic logic [1:0] mDec(input logic [15:0] c, output logic [10:0] d,
                                        output logic [15:0] fixedC);
        int s;
        s = 0;
        for (int pos = 1; pos < 16; pos++) if (c[pos]) s = s ^ pos;
        fixedC = c;
        if (($countones(c) % 2) == 1) begin
            fixedC[s] = ~fixedC[s];
            d = mExt(fixedC);
            return 2'b01;
        end
        d = mExt(c);
        return (s != 0) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- transaction driver ----------------
    task automatic doTxn(input bit inst, input bit cli, input bit we, input logic [3:0] addr,
                         input logic [10:0] wd, input logic [15:0] mask,
                         output logic [10:0] rd, output logic [1:0] er, output logic rid,
                         output int lat, output int wt);
        logic rdy, rv;
        @(negedge clk);
        inj_mask = mask;
        nMask    = mask;
        if (inst) begin
            nValid = 1'b1; nWe = we; nAddr = addr; nWdata = wd;
        end else if (cli) begin
            b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        wt = 0;
        #1;
        rdy = inst ? nReady : (cli ? b_ready : a_ready);
        while (!rdy && wt < 20) begin
            @(negedge clk);
            #1;
            wt++;
            rdy = inst ? nReady : (cli ? b_ready : a_ready);
        end
        rd = '0; er = '0; rid = 1'b0; lat = 99;
        if (!rdy) begin
            totalCnt++;
            $display("FAIL accept timeout: ready never seen, expected within 20 cycles");
            a_valid = 1'b0; b_valid = 1'b0; nValid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                a_valid = 1'b0; b_valid = 1'b0; nValid = 1'b0;
            end
            #1;
            rv = inst ? nRspValid : rsp_valid;
        end while (!rv && lat < 10);
        rd  = inst ? nRspRdata : rsp_rdata;
        er  = inst ? nRspErr   : rsp_err;
        rid = inst ? nRspId    : rsp_id;
    endtask

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [10:0] wd;
        logic [15:0] mask;
        logic [10:0] expRd;
        logic [1:0]  expErr;
        logic [3:0]  expLat;
        logic [15:0] expCorr;
        logic [15:0] expUncorr;
    } vecT;

    vecT vecs[12];

    logic [10:0] rd;
    logic [1:0]  er;
    logic        rid;
    int          lat, wt;

    logic [15:0] mStore[16];
    bit          mWritten[16];
    int          mCorr, mUncorr;

    initial begin
        vecs[0]  = '{1'b1, 4'd3, 11'h001, 16'h0000, 11'h000, 2'b00, 4'd2, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 4'd3, 11'h000, 16'h0000, 11'h001, 2'b00, 4'd3, 16'd0, 16'd0};
        vecs[2]  = '{1'b1, 4'd5, 11'h7FF, 16'h0000, 11'h000, 2'b00, 4'd2, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 4'd5, 11'h000, 16'h0000, 11'h7FF, 2'b00, 4'd3, 16'd0, 16'd0};
        vecs[4]  = '{1'b1, 4'd6, 11'h7FF, 16'h0020, 11'h000, 2'b00, 4'd2, 16'd0, 16'd0};
        vecs[5]  = '{1'b0, 4'd6, 11'h000, 16'h0000, 11'h7FF, 2'b01, 4'd4, 16'd1, 16'd0};
        vecs[6]  = '{1'b0, 4'd6, 11'h000, 16'h0000, 11'h7FF, 2'b00, 4'd3, 16'd1, 16'd0};
        vecs[7]  = '{1'b1, 4'd7, 11'h2A5, 16'h0001, 11'h000, 2'b00, 4'd2, 16'd1, 16'd0};
        vecs[8]  = '{1'b0, 4'd7, 11'h000, 16'h0000, 11'h2A5, 2'b01, 4'd4, 16'd2, 16'd0};
        vecs[9]  = '{1'b1, 4'd8, 11'h155, 16'h0022, 11'h000, 2'b00, 4'd2, 16'd2, 16'd0};
        vecs[10] = '{1'b0, 4'd8, 11'h000, 16'h0000, 11'h157, 2'b10, 4'd3, 16'd2, 16'd1};
        vecs[11] = '{1'b0, 4'd8, 11'h000, 16'h0000, 11'h157, 2'b10, 4'd3, 16'd2, 16'd2};

        a_valid = 0; b_valid = 0; a_we = 0; b_we = 0; a_addr = 0; b_addr = 0;
        a_wdata = 0; b_wdata = 0; inj_mask = 0;
        nValid = 0; nWe = 0; nAddr = 0; nWdata = 0; nMask = 0;

        // Reset with both clients requesting: nothing may be offered.
        rst_n = 1'b0;
        @(negedge clk);
        a_valid = 1; b_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        check("reset a_ready", a_ready, 0);
        check("reset b_ready", b_ready, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset corr_count", corr_count, 0);
        check("reset uncorr_count", uncorr_count, 0);
        a_valid = 0; b_valid = 0;
        rst_n = 1'b1;

        // Both held valid for four writes: A wins the first tie, then alternation.
        begin
            logic ids[4];
            int n, cyc, both;
            @(negedge clk);
            inj_mask = 0;
            a_valid = 1; a_we = 1; a_addr = 4'd10; a_wdata = 11'h0AA;
            b_valid = 1; b_we = 1; b_addr = 4'd11; b_wdata = 11'h055;
            n = 0; cyc = 0; both = 0;
            while (n < 4 && cyc < 60) begin
                #1;
                if (a_ready && b_ready) both++;
                if (rsp_valid) begin
                    ids[n] = rsp_id;
                    n++;
                end
                if (n < 4) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            a_valid = 0; b_valid = 0;
            check("tie responses seen", n, 4);
            check("tie both ready", both, 0);
            for (int i = 0; i < 4; i++) check($sformatf("tie grant %0d id", i), ids[i], i % 2);
        end

        // B alone is served without waiting; also reads back the tie-test data.
        doTxn(0, 1, 0, 4'd11, 0, 0, rd, er, rid, lat, wt);
        check("b alone wait", wt, 0);
        check("b alone latency", lat, 3);
        check("b alone id", rid, 1);
        check("b alone rdata", rd, 11'h055);
        doTxn(0, 0, 0, 4'd10, 0, 0, rd, er, rid, lat, wt);
        check("a read tie data", rd, 11'h0AA);

        // Directed table through client A.
        for (int i = 0; i < 12; i++) begin
            doTxn(0, 0, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].mask, rd, er, rid, lat, wt);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
            check($sformatf("vec%0d err", i), er, vecs[i].expErr);
            check($sformatf("vec%0d id", i), rid, 0);
            check($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
            check($sformatf("vec%0d corr_count", i), corr_count, vecs[i].expCorr);
            check($sformatf("vec%0d uncorr_count", i), uncorr_count, vecs[i].expUncorr);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d single pulse", i), rsp_valid, 0);
            if (i == 0) check("codeword addr3", dut.mem[3], 16'h000F);
            if (i == 2) check("codeword addr5", dut.mem[5], 16'hFFFF);
        end

        // Reset during CHECK of a single-error read: no response, no scrub, counters cleared.
        doTxn(0, 0, 1, 4'd12, 11'h321, 16'h0400, rd, er, rid, lat, wt);
        @(negedge clk);
        inj_mask = 0; a_valid = 1; a_we = 0; a_addr = 4'd12;
        #1;
        check("pre-abort a_ready", a_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 1;
        begin
            int rvSeen, rdySeen;
            rvSeen = 0; rdySeen = 0;
            repeat (4) begin
                @(negedge clk);
                #1;
                if (rsp_valid) rvSeen++;
                if (a_ready) rdySeen++;
            end
            check("abort rsp_valid", rvSeen, 0);
            check("abort ready in reset", rdySeen, 0);
        end
        check("abort corr_count", corr_count, 0);
        check("abort uncorr_count", uncorr_count, 0);
        a_valid = 0;
        rst_n = 1'b1;
        doTxn(0, 0, 0, 4'd12, 0, 0, rd, er, rid, lat, wt);
        check("post-abort err", er, 2'b01);
        check("post-abort rdata", rd, 11'h321);
        check("post-abort latency", lat, 4);
        check("post-abort corr_count", corr_count, 1);
        doTxn(0, 0, 0, 4'd12, 0, 0, rd, er, rid, lat, wt);
        check("scrubbed reread err", er, 2'b00);
        check("scrubbed reread corr_count", corr_count, 1);

        // Non-scrubbing build: the same error is reported and counted every time.
        doTxn(1, 0, 1, 4'd2, 11'h3C3, 16'h0100, rd, er, rid, lat, wt);
        check("noscrub write latency", lat, 2);
        for (int i = 0; i < 3; i++) begin
            doTxn(1, 0, 0, 4'd2, 0, 0, rd, er, rid, lat, wt);
            check($sformatf("noscrub read%0d err", i), er, 2'b01);
            check($sformatf("noscrub read%0d rdata", i), rd, 11'h3C3);
            check($sformatf("noscrub read%0d latency", i), lat, 3);
            check($sformatf("noscrub read%0d corr", i), nCorr, i + 1);
        end
        check("noscrub b_ready idle", nBReady, 0);
        check("noscrub rsp_id", nRspId, 0);

        // Randomized single-client traffic against the model.
        mCorr = 1; mUncorr = 0;
        for (int i = 0; i < 16; i++) mWritten[i] = 0;
        for (int i = 0; i < 80; i++) begin
            bit cli, doWr;
            logic [3:0] addr;
            logic [10:0] wd, expRd;
            logic [15:0] mask, fixedC;
            logic [1:0] expErr;
            int b0, b1, expLat;
            cli  = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            doWr = !mWritten[addr] || ($urandom_range(0, 2) == 0);
            wd   = 11'($urandom);
            mask = '0;
            case ($urandom_range(0, 2))
                1: begin
                    b0 = $urandom_range(0, 15);
                    mask[b0] = 1'b1;
                end
                2: begin
                    b0 = $urandom_range(0, 15);
                    b1 = (b0 + $urandom_range(1, 15)) % 16;
                    mask[b0] = 1'b1;
                    mask[b1] = 1'b1;
                end
                default: ;
            endcase
            if (doWr) begin
                mStore[addr]   = mEnc(wd) ^ mask;
                mWritten[addr] = 1;
                expRd = '0; expErr = 2'b00; expLat = 2;
            end else begin
                expErr = mDec(mStore[addr], expRd, fixedC);
                expLat = 3;
                if (expErr == 2'b01) begin
                    mCorr++;
                    mStore[addr] = fixedC;
                    expLat = 4;
                end
                if (expErr == 2'b10) mUncorr++;
            end
            doTxn(0, cli, doWr, addr, wd, mask, rd, er, rid, lat, wt);
            check($sformatf("rnd%0d rdata", i), rd, expRd);
            check($sformatf("rnd%0d err", i), er, expErr);
            check($sformatf("rnd%0d id", i), rid, cli);
            check($sformatf("rnd%0d latency", i), lat, expLat);
            check($sformatf("rnd%0d corr_count", i), corr_count, mCorr);
            check($sformatf("rnd%0d uncorr_count", i), uncorr_count, mUncorr);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
